sram_sample_reader: RTL

//  Read-side SRAM initiator: streams 16-bit audio samples out of the 256Kx16 board SRAM.

---
 rtl/sram_reader_pkg.sv | 13 +
 rtl/sample_fifo.sv | 54 +++++
 rtl/sram_sample_reader.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/sram_reader_pkg.sv
// Shared types and constants for the SRAM sample reader: FSM state encoding
// and the board SRAM geometry (256K x 16).
package sram_reader_pkg;
  localparam int SRAM_ADDR_W = 18;
  localparam int SRAM_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } state_t;
endpackage

// File: rtl/sample_fifo.sv
// Small synchronous FIFO between the SRAM capture point and the sample stream.
// rd_data is the head entry; flush empties the FIFO in one cycle.
module sample_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read once counted in.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wr_data;
  end
endmodule

// File: rtl/sram_sample_reader.sv
// Read-only SRAM initiator streaming `length` words from `base_addr` into a
// valid/ready sample stream. Define READER_STATS_EN to enable underrun_cnt.
module sram_sample_reader
  import sram_reader_pkg::*;
#(
  parameter int ADDR_W     = SRAM_ADDR_W,
  parameter int DATA_W     = SRAM_DATA_W,
  parameter int FIFO_DEPTH = 4,
  parameter int READ_WAIT  = 1
) (
  input  logic              CLOCK_50,
  input  logic              RESET_N,
  input  logic              start,
  input  logic              stop,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] length,
  input  logic              loop_en,
  output logic [DATA_W-1:0] sample_data,
  output logic              sample_valid,
  input  logic              sample_ready,
  output logic              busy,
  output logic              done,
  output logic [15:0]       underrun_cnt,
  output state_t            fsm_state,
  output logic [ADDR_W-1:0] SRAM_ADDR,
  inout  wire  [DATA_W-1:0] SRAM_DQ,
  output logic              SRAM_WE_N,
  output logic              SRAM_CE_N,
  output logic              SRAM_OE_N,
  output logic              SRAM_UB_N,
  output logic              SRAM_LB_N
);
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int WAIT_W = (READ_WAIT > 1) ? $clog2(READ_WAIT) : 1;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] base_q, len_q, cnt_q;
  logic              loop_q;
  logic [WAIT_W-1:0] wcnt_q;
  logic              done_set;
  logic              accept_start, issue, capture, last_word, wait_last;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full, fifo_empty;

  assign SRAM_DQ   = {DATA_W{1'bz}};
  assign SRAM_WE_N = 1'b1;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign busy      = (state != IDLE);
  assign SRAM_CE_N = ~busy;
  assign SRAM_OE_N = ~busy;
  assign fsm_state = state;

  assign accept_start = (state == IDLE) & start & ~stop;
  // Only one read is ever outstanding, so in ISSUE the in-flight count is zero.
  assign issue        = (state == ISSUE) & ~stop & (fifo_count < CNT_W'(FIFO_DEPTH));
  assign wait_last    = (wcnt_q == WAIT_W'(READ_WAIT - 1));
  assign capture      = (state == WAIT) & wait_last & ~stop;
  assign last_word    = (ADDR_W'(cnt_q + 1'b1) == len_q);

  always_comb begin
    state_nx = state;
    done_set = 1'b0;
    if (stop) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (length != '0) state_nx = ISSUE;
            else              done_set = 1'b1;
          end
        end
        ISSUE: if (issue) state_nx = WAIT;
        WAIT: begin
          if (capture) state_nx = (last_word && !loop_q) ? DRAIN : ISSUE;
        end
        DRAIN: begin
          if (fifo_empty) begin
            state_nx = IDLE;
            done_set = 1'b1;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= IDLE;
      done      <= 1'b0;
      base_q    <= '0;
      len_q     <= '0;
      loop_q    <= 1'b0;
      cnt_q     <= '0;
      wcnt_q    <= '0;
      SRAM_ADDR <= '0;
    end else begin
      state <= state_nx;
      done  <= done_set;
      if (accept_start) begin
        base_q <= base_addr;
        len_q  <= length;
        loop_q <= loop_en;
        cnt_q  <= '0;
      end else if (capture) begin
        cnt_q <= (last_word && loop_q) ? '0 : cnt_q + 1'b1;
      end
      if (issue) begin
        SRAM_ADDR <= base_q + cnt_q;
        wcnt_q    <= '0;
      end else if (state == WAIT && !wait_last) begin
        wcnt_q <= wcnt_q + 1'b1;
      end
    end
  end

  // Stream handshake: a word transfers on every edge where sample_valid and
  // sample_ready are both high; sample_data is stable while valid & !ready.
  sample_fifo #(
    .WIDTH(DATA_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk     (CLOCK_50),
    .rst_n   (RESET_N),
    .flush   (stop),
    .push    (capture & ~fifo_full),
    .wr_data (SRAM_DQ),
    .pop     (sample_valid & sample_ready),
    .rd_data (sample_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign sample_valid = ~fifo_empty;

`ifdef READER_STATS_EN
  logic [15:0] under_q;
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      under_q <= '0;
    end else if (accept_start) begin
      under_q <= '0;
    end else if (busy && sample_ready && !sample_valid && under_q != 16'hFFFF) begin
      under_q <= under_q + 16'd1;
    end
  end
  assign underrun_cnt = under_q;
`else
  assign underrun_cnt = 16'h0000;
`endif
endmodule
